ad7276_serial_responder: RTL and testbench

//  Bench-side and loopback model of the AD7276 ADC serial port. It is the responder end of the
//  cs_n/sclk/sdata link that the ad7276 capture IP drives as master.
//  12-bit codes arrive on an AXI4-Stream slave and are queued in a small FIFO.

---
 rtl/ad7276_serial_responder.sv | 184 ++++++++++++++++++
 tb/tb_ad7276_serial_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ad7276_serial_responder.sv
// AD7276 serial-port responder: queues 12-bit codes from AXI4-Stream and shifts one
// code per cs_n frame on sdata, with cs_n/sclk oversampled in the system clock domain.
module ad7276_serial_responder #(
  parameter int unsigned          DATA_BITS   = 12,
  parameter int unsigned          LEAD_ZEROS  = 2,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter int unsigned          FIFO_DEPTH  = 4,
  parameter logic [DATA_BITS-1:0] IDLE_CODE   = '0
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        cs_n,
  input  logic        sclk,
  output logic        sdata,
  output logic        sdata_oe,
  output logic        busy,
  output logic [31:0] frame_count,
  output logic [15:0] underrun_count
);

  localparam int unsigned W  = LEAD_ZEROS + DATA_BITS;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

  // ---------------- input synchronisers and edge detect ----------------
  logic [SYNC_STAGES-1:0] cs_sync, sk_sync;
  logic                   cs_d, sk_d;
  logic                   cs_s, sk_s;
  logic                   cs_fall, cs_rise, sclk_fall;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cs_sync <= '1;
      sk_sync <= '1;
      cs_d    <= 1'b1;
      sk_d    <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sk_sync <= {sk_sync[SYNC_STAGES-2:0], sclk};
      cs_d    <= cs_s;
      sk_d    <= sk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sk_s      = sk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_fall = sk_d & ~sk_s & ~cs_s;

  // ---------------- code FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty;
  logic                 ready_en;
  logic                 push, pop, pop_req;
  logic [DATA_BITS-1:0] head;

  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign s_axis_tready = ready_en & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = pop_req & ~empty;
  assign head          = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge s_axis_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata[DATA_BITS-1:0];
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  state_t               state, state_nx;
  logic [W-1:0]         shreg, shreg_nx;
  logic [CW-1:0]        bcnt, bcnt_nx;
  logic                 sdata_nx, oe_nx, busy_nx;
  logic                 frame_inc, under_inc;
  logic [DATA_BITS-1:0] code_sel;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state    <= IDLE;
      shreg    <= '0;
      bcnt     <= '0;
      sdata    <= 1'b0;
      sdata_oe <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bcnt     <= bcnt_nx;
      sdata    <= sdata_nx;
      sdata_oe <= oe_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bcnt_nx   = bcnt;
    sdata_nx  = sdata;
    oe_nx     = sdata_oe;
    busy_nx   = busy;
    frame_inc = 1'b0;
    under_inc = 1'b0;
    pop_req   = 1'b0;
    code_sel  = empty ? IDLE_CODE : head;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          pop_req   = 1'b1;
          under_inc = empty;
          shreg_nx  = W'(code_sel);
          sdata_nx  = shreg_nx[W-1];
          oe_nx     = 1'b1;
          busy_nx   = 1'b1;
          bcnt_nx   = CW'(1);
          state_nx  = SHIFT;
        end
      end
      SHIFT: begin
        // cs_rise outranks a coincident sclk_fall; leaving here means the frame was aborted
        if (cs_rise) begin
          sdata_nx = 1'b0;
          oe_nx    = 1'b0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (sclk_fall) begin
          if (bcnt == CW'(W)) begin
            sdata_nx = 1'b0;
            state_nx = TRAIL;
          end else begin
            shreg_nx = shreg << 1;
            sdata_nx = shreg_nx[W-1];
            bcnt_nx  = bcnt + 1'b1;
          end
        end
      end
      TRAIL: begin
        sdata_nx = 1'b0;
        if (cs_rise) begin
          oe_nx     = 1'b0;
          busy_nx   = 1'b0;
          frame_inc = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: begin
        sdata_nx = 1'b0;
        oe_nx    = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------- statistics ----------------
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      frame_count    <= '0;
      underrun_count <= '0;
    end else begin
      if (frame_inc) frame_count <= frame_count + 1'b1;
      if (under_inc && (underrun_count != '1)) underrun_count <= underrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad7276_serial_responder.sv
// Directed plus randomized bench for ad7276_serial_responder against a queue-based
// reference model of codes, frames and underruns.
module tb_ad7276_serial_responder;

  localparam int W    = 14;
  localparam int HALF = 5;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        cs_n;
  logic        sclk;
  logic        sdata;
  logic        sdata_oe;
  logic        busy;
  logic [31:0] frame_count;
  logic [15:0] underrun_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned q[$];
  int unsigned m_frames = 0;
  int unsigned m_under  = 0;

  always #5 clk = ~clk;

  ad7276_serial_responder #(
    .DATA_BITS(12), .LEAD_ZEROS(2), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .IDLE_CODE(12'h000)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .cs_n(cs_n),
    .sclk(sclk),
    .sdata(sdata),
    .sdata_oe(sdata_oe),
    .busy(busy),
    .frame_count(frame_count),
    .underrun_count(underrun_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned code, output bit acc);
    @(negedge clk);
    tdata  = ($urandom & 32'hFFFF_F000) | (code & 32'hFFF);
    tvalid = 1'b1;
    acc    = tready;
    if (acc) q.push_back(code & 32'hFFF);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  // Expected bit i of a frame: W-bit word {2'b00, code}, MSB first, zeros past the LSB.
  task automatic run_frame(input int nfalls, input string tag);
    int unsigned code;
    int unsigned expb;
    if (q.size() == 0) begin
      code = 0;
      if (m_under < 16'hFFFF) m_under++;
    end else begin
      code = q.pop_front();
    end
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(HALF);
    chk({tag, "_oe"}, sdata_oe, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_tready"}, tready, (q.size() < DEPTH) ? 1 : 0);
    for (int i = 0; i < nfalls; i++) begin
      expb = (i < W) ? ((code >> (W - 1 - i)) & 1) : 0;
      chk($sformatf("%s_bit%0d", tag, i), sdata, expb);
      sclk = 1'b0;
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
    end
    cs_n = 1'b1;
    if (nfalls >= W) m_frames++;
    wait_clks(HALF);
    chk({tag, "_oe_end"}, sdata_oe, 0);
    chk({tag, "_sdata_end"}, sdata, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_frames"}, frame_count, m_frames);
    chk({tag, "_under"}, underrun_count, m_under);
  endtask

  initial begin
    bit acc;
    int unsigned n;
    rst_n  = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    cs_n   = 1'b1;
    sclk   = 1'b1;

    // Reset state and tready release timing
    wait_clks(3);
    chk("rst_sdata", sdata, 0);
    chk("rst_oe", sdata_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_under", underrun_count, 0);
    chk("rst_tready", tready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready0", tready, 0);
    @(negedge clk);
    chk("rel_tready1", tready, 1);

    // Single known code
    push(12'hA5C, acc);
    chk("a5c_acc", acc, 1);
    run_frame(W, "a5c");

    // Empty queue -> idle code and underrun
    run_frame(W, "under");
    chk("under_tready", tready, 1);

    // Fill to depth, fifth push refused
    for (int i = 1; i <= DEPTH; i++) begin
      push(i, acc);
      chk($sformatf("fill_acc%0d", i), acc, 1);
    end
    chk("full_tready", tready, 0);
    push(5, acc);
    chk("over_acc", acc, 0);
    run_frame(W, "pop1");
    chk("after_pop_tready", tready, 1);

    // Aborted frame consumes code 2; next frame sends code 3
    run_frame(6, "abort");
    run_frame(W, "next");
    run_frame(W + 3, "trail");

    // Randomized pushes and frame lengths
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < int'(n); k++) begin
        push($urandom_range(0, 4095), acc);
        chk($sformatf("rnd%0d_acc", it), acc, (q.size() <= DEPTH && acc) ? 1 : 0);
      end
      run_frame($urandom_range(2, 18), $sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_tready", it), tready, (q.size() < DEPTH) ? 1 : 0);
    end

    // Reset asserted mid-SHIFT
    push(12'hFFF, acc);
    push(12'h123, acc);
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0;
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_oe", sdata_oe, 0);
    chk("mid_sdata", sdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_frames", frame_count, 0);
    chk("mid_under", underrun_count, 0);
    chk("mid_tready", tready, 0);
    cs_n = 1'b1;
    sclk = 1'b1;
    q.delete();
    m_frames = 0;
    m_under  = 0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
    chk("post_rst_tready", tready, 1);
    run_frame(W, "flushed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
